light_separator_ctrl: RTL and testbench
=======================================

# light_separator_ctrl

Sequencing controller for the light separator conveyor. It accepts one strobe per object passing the light sensor and classifies the object as light or dark against a programmable threshold. It holds the classification in a time-stamped queue for the sensor-to-gate travel time, then drives the matching ejector gate for a fixed pulse. It sits between the sensor front end and the gate actuators inside the separator wrapper.

## Interface
- DATA_W, 8, sensor intensity width
- DEPTH, 8, queue entries (power of 2, >= 2)
- TRAVEL, 16, clock cycles from sensor strobe to gate; legal range 3..65535
- PULSE, 4, gate pulse length in cycles; also the minimum object spacing; legal range 1..TRAVEL-1
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- obj_stb  in  1  single-cycle strobe: an object is at the sensor
- obj_light  in  DATA_W  sensor intensity, valid with obj_stb
- threshold  in  DATA_W  classification threshold, sampled with obj_stb
- clr_err  in  1  clears err_drop
- gate_light  out  1  ejector to the light bin
- gate_dark  out  1  ejector to the dark bin
- busy  out  1  queue non-empty or pulse active
- err_drop  out  1  sticky: an object was dropped
- cnt_light  out  16  light objects ejected (saturating)
- cnt_dark  out  16  dark objects ejected (saturating)
- cnt_drop  out  16  objects dropped (saturating)

## Operation
- Free-running 16-bit timer `tmr`, increments every cycle and wraps mod 2^16.
- Accept condition: obj_stb && !full && space_cnt==0.
  - On accept: push {cls, due}, with cls = (obj_light >= threshold) (1 = light) and due = tmr + TRAVEL (mod 2^16).
  - On accept: load space_cnt = PULSE-1, which then decrements to 0.
- Drop: obj_stb while full or space_cnt!=0. No push; err_drop<=1; cnt_drop++. The object passes to the default bin.
- Spacing guarantees consecutive due values differ by >= PULSE, so pulses never overlap.
- FSM states:
  - IDLE: queue empty, gates low. Goes to WAIT on push.
  - WAIT: compares the head entry's due with tmr. On equality, pops the head and goes to FIRE with the gate for cls asserted.
  - FIRE: pulse counter runs PULSE cycles, with exactly one gate high. At the end it goes to WAIT if the queue is non-empty, else IDLE.
- Simultaneous push and pop are allowed in the same cycle. Occupancy is unchanged; full and empty are evaluated on pre-edge state.
- Counters cnt_light and cnt_dark increment at the pop. All counters saturate at 16'hFFFF.
- clr_err clears err_drop. If a drop occurs in the same cycle as clr_err, the drop wins and err_drop stays 1.
- threshold may change at any time; only the value present at the strobe matters.

## Timing
- Reset values: gate_light=0, gate_dark=0, busy=0, err_drop=0, all counters 0, tmr=0, queue empty, FSM=IDLE, space_cnt=0.
- Accept at edge E → the selected gate goes high at edge E+TRAVEL and stays high for PULSE cycles. It falls at edge E+TRAVEL+PULSE.
- Gates are registered outputs with no combinational path from inputs.
- busy rises at edge E (first push) and falls on the edge where the last pulse ends with the queue empty.
- err_drop and cnt_drop update on the edge of the dropping strobe.
- Next strobe acceptable at edge E+PULSE or later.
- Reset mid-pulse: gates are low after the reset edge. Queue, FSM and timer are cleared, and pending objects are discarded without counting.
- Timer wrap: due compare is pure equality mod 2^16, so wrap is transparent. Every entry fires exactly once within TRAVEL cycles.

## Configuration
- LIGHT_SEP_STATS_EN defined: cnt_light, cnt_dark and cnt_drop are implemented as above.
- LIGHT_SEP_STATS_EN undefined: all three counter outputs are tied to 0 with no counter flops. err_drop and all sequencing are unaffected.

## Test plan
- Defaults, threshold=8'h80, strobe obj_light=8'hC0 at edge E → gate_light high for edges E+16..E+19, gate_dark stays 0, cnt_light=1.
- obj_light=8'h7F, threshold=8'h80 → gate_dark pulse at E+16 for 4 cycles. With obj_light=8'h80 the result is light (equality boundary).
- Strobes at E and E+4, light then dark → back-to-back pulses: gate_light for edges E+16..E+19, gate_dark for edges E+20..E+23, no gap and no overlap.
- Strobes at E and E+2 → second dropped: err_drop=1, cnt_drop=1, one pulse only. Then clr_err → err_drop=0.
- TRAVEL=60, PULSE=4, DEPTH=8: 9 strobes spaced 4 cycles apart → first 8 eject in order, the 9th is dropped. Also start with tmr near 16'hFFF8 so due values wrap; all 8 still fire on time.
- Assert rst_n=0 for one cycle during a gate pulse with 3 entries queued → gates low next cycle, busy=0, and no further pulses.

Source files
------------

// File: rtl/light_separator_ctrl_if.sv
// Bus bundle between the sensor front end, the gate actuators and the
// light separator sequencing controller.
interface light_separator_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              obj_stb;
  logic [DATA_W-1:0] obj_light;
  logic [DATA_W-1:0] threshold;
  logic              clr_err;
  logic              gate_light;
  logic              gate_dark;
  logic              busy;
  logic              err_drop;
  logic [15:0]       cnt_light;
  logic [15:0]       cnt_dark;
  logic [15:0]       cnt_drop;

  modport master (
    output obj_stb, obj_light, threshold, clr_err,
    input  gate_light, gate_dark, busy, err_drop, cnt_light, cnt_dark, cnt_drop
  );

  modport slave (
    input  obj_stb, obj_light, threshold, clr_err,
    output gate_light, gate_dark, busy, err_drop, cnt_light, cnt_dark, cnt_drop
  );
endinterface

// File: rtl/light_separator_ctrl.sv
// Light separator sequencing controller.
// Classifies each strobed object against a threshold, holds {class, due time}
// in a queue for the sensor-to-gate travel time, then pulses the matching gate.
// Optional macro LIGHT_SEP_STATS_EN: implements the saturating light/dark/drop
// counters; when undefined the counter outputs are tied to zero.
module light_separator_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int TRAVEL = 16,
  parameter int PULSE  = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  light_separator_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIRE} state_t;

  typedef struct packed {
    logic        cls;   // 1 = light
    logic [15:0] due;   // timer value at which the gate must open
  } entry_t;

  state_t            state_q, state_d;
  logic [15:0]       tmr_q, tmr_d;
  logic [15:0]       space_q, space_d;
  logic [15:0]       pulse_q, pulse_d;
  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  entry_t            queue_q [DEPTH];
  entry_t            queue_d [DEPTH];
  logic              gate_light_q, gate_light_d;
  logic              gate_dark_q, gate_dark_d;
  logic              busy_q, busy_d;
  logic              err_drop_q, err_drop_d;

  logic [AW:0]       count;
  logic              full, empty, accept, drop, pop, head_due;
  entry_t            head;
  logic [DATA_W-1:0] obj_light, threshold;

  assign obj_light = bus.obj_light;
  assign threshold = bus.threshold;
  assign count     = wr_q - rd_q;
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head      = queue_q[rd_q[AW-1:0]];
  assign head_due  = !empty && (head.due == tmr_q);
  assign accept    = bus.obj_stb && !full && (space_q == '0);
  assign drop      = bus.obj_stb && !accept;

  // Gate sequencing: wait for the head entry's due time, then hold one gate for PULSE cycles.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    pulse_d      = pulse_q;
    gate_light_d = gate_light_q;
    gate_dark_d  = gate_dark_q;
    pop          = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (head_due) begin
          pop          = 1'b1;
          state_d      = S_FIRE;
          pulse_d      = 16'(PULSE - 1);
          gate_light_d = head.cls;
          gate_dark_d  = !head.cls;
        end
      end
      S_FIRE: begin
        if (pulse_q != '0) begin
          pulse_d = pulse_q - 16'd1;
        end else if (head_due) begin
          // Next entry is due exactly as this pulse ends: fire back-to-back.
          pop          = 1'b1;
          pulse_d      = 16'(PULSE - 1);
          gate_light_d = head.cls;
          gate_dark_d  = !head.cls;
        end else begin
          gate_light_d = 1'b0;
          gate_dark_d  = 1'b0;
          state_d      = (empty && !accept) ? S_IDLE : S_WAIT;
        end
      end
      default: begin
        state_d      = S_IDLE;
        gate_light_d = 1'b0;
        gate_dark_d  = 1'b0;
      end
    endcase
  end

  // Queue pointers, timer, object spacing and the sticky drop flag.
  always_comb begin
    queue_d = queue_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    tmr_d   = tmr_q + 16'd1;
    space_d = (space_q != '0) ? space_q - 16'd1 : space_q;
    if (accept) begin
      queue_d[wr_q[AW-1:0]] = '{cls: (obj_light >= threshold), due: tmr_q + 16'(TRAVEL)};
      wr_d    = wr_q + 1'b1;
      space_d = 16'(PULSE - 1);
    end
    if (pop) rd_d = rd_q + 1'b1;
    err_drop_d = err_drop_q;
    if (bus.clr_err) err_drop_d = 1'b0;
    if (drop)        err_drop_d = 1'b1;
    busy_d = (wr_d != rd_d) || (state_d == S_FIRE);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    // NOTE: all state flops take non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      space_q      <= '0;
      pulse_q      <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      gate_light_q <= 1'b0;
      gate_dark_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      space_q      <= space_d;
      pulse_q      <= pulse_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      gate_light_q <= gate_light_d;
      gate_dark_q  <= gate_dark_d;
      busy_q       <= busy_d;
      err_drop_q   <= err_drop_d;
    end
  end

  // Queue storage.
  always_ff @(posedge clk) begin
    // NOTE: entries carry no reset; the pointers alone decide which entries are valid.
    queue_q <= queue_d;
  end

  assign bus.gate_light = gate_light_q;
  assign bus.gate_dark  = gate_dark_q;
  assign bus.busy       = busy_q;
  assign bus.err_drop   = err_drop_q;

`ifdef LIGHT_SEP_STATS_EN
  logic [15:0] cnt_light_q, cnt_light_d;
  logic [15:0] cnt_dark_q, cnt_dark_d;
  logic [15:0] cnt_drop_q, cnt_drop_d;

  // Saturating event counters: ejections counted at the pop, drops at the strobe.
  always_comb begin
    cnt_light_d = cnt_light_q;
    cnt_dark_d  = cnt_dark_q;
    cnt_drop_d  = cnt_drop_q;
    if (pop && head.cls && (cnt_light_q != 16'hFFFF))  cnt_light_d = cnt_light_q + 16'd1;
    if (pop && !head.cls && (cnt_dark_q != 16'hFFFF))  cnt_dark_d  = cnt_dark_q + 16'd1;
    if (drop && (cnt_drop_q != 16'hFFFF))              cnt_drop_d  = cnt_drop_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_light_q <= '0;
      cnt_dark_q  <= '0;
      cnt_drop_q  <= '0;
    end else begin
      cnt_light_q <= cnt_light_d;
      cnt_dark_q  <= cnt_dark_d;
      cnt_drop_q  <= cnt_drop_d;
    end
  end

  assign bus.cnt_light = cnt_light_q;
  assign bus.cnt_dark  = cnt_dark_q;
  assign bus.cnt_drop  = cnt_drop_q;
`else
  assign bus.cnt_light = '0;
  assign bus.cnt_dark  = '0;
  assign bus.cnt_drop  = '0;
`endif

endmodule

// File: tb/tb_light_separator_ctrl.sv
// Directed bench for light_separator_ctrl: a default instance (TRAVEL=16,
// PULSE=4) and a long-travel instance (TRAVEL=60) used for the full-queue and
// timer-wrap scenario.
module tb_light_separator_ctrl;
`ifdef LIGHT_SEP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  always #5 clk = ~clk;

  light_separator_ctrl_if #(.DATA_W(8)) bus_a ();
  light_separator_ctrl_if #(.DATA_W(8)) bus_b ();

  light_separator_ctrl #(.DATA_W(8), .DEPTH(8), .TRAVEL(16), .PULSE(4)) dut (
    .clk(clk), .rst_n(rst_n_a), .bus(bus_a)
  );
  light_separator_ctrl #(.DATA_W(8), .DEPTH(8), .TRAVEL(60), .PULSE(4)) dut60 (
    .clk(clk), .rst_n(rst_n_b), .bus(bus_b)
  );

  typedef struct {
    logic [7:0] light;
    logic [7:0] thr;
    logic       exp_light;
    string      name;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int m_light = 0, m_dark = 0, m_drop = 0;   // default-instance model counts

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ecnt(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts_a(input string tag);
    check({tag, " cnt_light"}, bus_a.cnt_light, ecnt(m_light));
    check({tag, " cnt_dark"},  bus_a.cnt_dark,  ecnt(m_dark));
    check({tag, " cnt_drop"},  bus_a.cnt_drop,  ecnt(m_drop));
  endtask

  // Strobe one object on the default instance and check its whole pulse window.
  task automatic apply_obj(input vec_t v);
    bus_a.obj_stb = 1'b1; bus_a.obj_light = v.light; bus_a.threshold = v.thr;
    step();                                   // edge E
    bus_a.obj_stb = 1'b0; bus_a.threshold = ~v.thr;  // later threshold changes must not matter
    check({v.name, " busy rise"}, bus_a.busy, 1);
    repeat (15) step();                       // edge E+15
    check({v.name, " gates before due"}, {bus_a.gate_light, bus_a.gate_dark}, 2'b00);
    for (int k = 0; k < 4; k++) begin         // edges E+16..E+19
      step();
      check({v.name, " pulse"}, {bus_a.gate_light, bus_a.gate_dark}, {v.exp_light, !v.exp_light});
    end
    step();                                   // edge E+20
    check({v.name, " gates after pulse"}, {bus_a.gate_light, bus_a.gate_dark}, 2'b00);
    check({v.name, " busy fall"}, bus_a.busy, 0);
    if (v.exp_light) m_light++; else m_dark++;
    check_cnts_a(v.name);
  endtask

  initial begin
    vec_t vecs [7];
    logic [7:0] cls_b;
    logic       seen;
    int         nl_b;

    vecs[0] = '{8'hC0, 8'h80, 1'b1, "light C0/80"};
    vecs[1] = '{8'h7F, 8'h80, 1'b0, "dark 7F/80"};
    vecs[2] = '{8'h80, 8'h80, 1'b1, "equal 80/80"};
    vecs[3] = '{8'h00, 8'h00, 1'b1, "zero 00/00"};
    vecs[4] = '{8'hFE, 8'hFF, 1'b0, "dark FE/FF"};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, "max FF/FF"};
    vecs[6] = '{8'h00, 8'h01, 1'b0, "dark 00/01"};

    bus_a.obj_stb = 1'b0; bus_a.obj_light = '0; bus_a.threshold = 8'h80; bus_a.clr_err = 1'b0;
    bus_b.obj_stb = 1'b0; bus_b.obj_light = '0; bus_b.threshold = 8'h80; bus_b.clr_err = 1'b0;

    // Reset state
    repeat (2) step();
    check("reset gates", {bus_a.gate_light, bus_a.gate_dark}, 2'b00);
    check("reset busy", bus_a.busy, 0);
    check("reset err_drop", bus_a.err_drop, 0);
    check_cnts_a("reset");
    rst_n_a = 1'b1;
    repeat (3) step();

    // Classification table
    foreach (vecs[i]) begin
      apply_obj(vecs[i]);
      repeat (2) step();
    end

    // Back-to-back: light at E, dark at E+4
    bus_a.threshold = 8'h80;
    bus_a.obj_stb = 1'b1; bus_a.obj_light = 8'hC0;
    step();                                   // E
    bus_a.obj_stb = 1'b0;
    repeat (3) step();                        // E+3
    bus_a.obj_stb = 1'b1; bus_a.obj_light = 8'h10;
    step();                                   // E+4
    bus_a.obj_stb = 1'b0;
    check("b2b no drop", bus_a.err_drop, 0);
    repeat (11) step();                       // E+15
    check("b2b gates before due", {bus_a.gate_light, bus_a.gate_dark}, 2'b00);
    for (int k = 0; k < 8; k++) begin         // E+16..E+23
      step();
      check("b2b pulse", {bus_a.gate_light, bus_a.gate_dark}, (k < 4) ? 2'b10 : 2'b01);
    end
    step();                                   // E+24
    check("b2b gates after", {bus_a.gate_light, bus_a.gate_dark}, 2'b00);
    check("b2b busy fall", bus_a.busy, 0);
    m_light++; m_dark++;
    check_cnts_a("b2b");
    repeat (2) step();

    // Spacing violation: accept at E, drops at E+2 and E+3 (the latter with clr_err)
    bus_a.obj_stb = 1'b1; bus_a.obj_light = 8'hC0;
    step();                                   // E
    bus_a.obj_stb = 1'b0;
    step();                                   // E+1
    bus_a.obj_stb = 1'b1; bus_a.obj_light = 8'h10;
    step();                                   // E+2
    m_drop++;
    check("drop err_drop set", bus_a.err_drop, 1);
    check("drop cnt_drop", bus_a.cnt_drop, ecnt(m_drop));
    bus_a.clr_err = 1'b1;
    step();                                   // E+3: drop and clear together
    m_drop++;
    check("drop beats clr_err", bus_a.err_drop, 1);
    bus_a.obj_stb = 1'b0;
    step();                                   // E+4: clear only
    bus_a.clr_err = 1'b0;
    check("clr_err clears", bus_a.err_drop, 0);
    repeat (11) step();                       // E+15
    check("drop gates before due", {bus_a.gate_light, bus_a.gate_dark}, 2'b00);
    for (int k = 0; k < 4; k++) begin
      step();
      check("drop single pulse", {bus_a.gate_light, bus_a.gate_dark}, 2'b10);
    end
    step();                                   // E+20
    check("drop gates after", {bus_a.gate_light, bus_a.gate_dark}, 2'b00);
    check("drop busy fall", bus_a.busy, 0);
    m_light++;
    check_cnts_a("drop");
    repeat (2) step();

    // Reset mid-pulse with three entries still queued
    for (int i = 0; i < 4; i++) begin
      bus_a.obj_stb = 1'b1; bus_a.obj_light = i[0] ? 8'h10 : 8'hC0;
      step();                                 // E+4i
      bus_a.obj_stb = 1'b0;
      if (i < 3) repeat (3) step();
    end                                       // now E+12
    repeat (4) step();                        // E+16
    check("rst pulse active", {bus_a.gate_light, bus_a.gate_dark}, 2'b10);
    rst_n_a = 1'b0;
    step();                                   // E+17
    rst_n_a = 1'b1;
    m_light = 0; m_dark = 0; m_drop = 0;
    check("rst gates low", {bus_a.gate_light, bus_a.gate_dark}, 2'b00);
    check("rst busy low", bus_a.busy, 0);
    check_cnts_a("rst");
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      seen = seen | bus_a.gate_light | bus_a.gate_dark | bus_a.busy;
    end
    check("rst no further activity", seen, 0);

    // Long travel, full queue and timer wrap on the TRAVEL=60 instance.
    // Reset edge R leaves tmr=0; the first strobe edge then sees tmr=16'hFFF8.
    step();                                   // R
    rst_n_b = 1'b1;
    repeat (16'hFFF8) step();
    cls_b = 8'b1011_0010;
    nl_b  = 0;
    for (int i = 0; i < 9; i++) begin
      bus_b.obj_stb = 1'b1;
      bus_b.obj_light = (i < 8 && cls_b[i]) ? 8'hF0 : 8'h05;
      step();                                 // E+4i
      bus_b.obj_stb = 1'b0;
      if (i == 7) check("full no drop yet", bus_b.err_drop, 0);
      if (i < 8) repeat (3) step();
    end                                       // E+32
    check("full 9th dropped", bus_b.err_drop, 1);
    check("full cnt_drop", bus_b.cnt_drop, ecnt(1));
    seen = 1'b0;
    for (int k = 0; k < 27; k++) begin        // E+33..E+59
      step();
      seen = seen | bus_b.gate_light | bus_b.gate_dark;
    end
    check("wrap gates before due", seen, 0);
    for (int k = 0; k < 32; k++) begin        // E+60..E+91
      step();
      check("wrap pulse order", {bus_b.gate_light, bus_b.gate_dark},
            {cls_b[k/4], !cls_b[k/4]});
    end
    step();                                   // E+92
    check("wrap gates after", {bus_b.gate_light, bus_b.gate_dark}, 2'b00);
    check("wrap busy fall", bus_b.busy, 0);
    for (int i = 0; i < 8; i++) if (cls_b[i]) nl_b++;
    check("wrap cnt_light", bus_b.cnt_light, ecnt(nl_b));
    check("wrap cnt_dark", bus_b.cnt_dark, ecnt(8 - nl_b));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
